// File: rtl/cpu_defs.sv
// Shared definitions for the instruction-memory loader and its users.
package cpu_defs;

  localparam int unsigned IMEM_ADDR_W  = 8;
  localparam logic [7:0]  LOADER_MAGIC = 8'hA5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DATA  = 2'd2,
    CSUM  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte idle counter: clears on demand, counts while enabled and
// flags expiry once TIMEOUT idle cycles have elapsed.
module loader_timeout #(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CW'(TIMEOUT));

  // Next count: clear wins, otherwise count up and hold at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// Framed UART byte stream to instruction-RAM writer. Assembles big-endian
// words, writes them from address 0 upward and holds the CPU in reset
// until a frame's checksum verifies.
module imem_uart_loader
  import cpu_defs::*;
#(
  parameter int unsigned ADDR_W  = IMEM_ADDR_W,
  parameter int unsigned TIMEOUT = 1000000,
  parameter logic [7:0]  MAGIC   = LOADER_MAGIC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned     WCW      = ADDR_W + 1;
  localparam logic [WCW-1:0]  WCNT_ONE = WCW'(1);
  localparam logic [WCW-1:0]  WCNT_MAX = WCW'(1) << ADDR_W;

  loader_state_e     state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [WCW-1:0]    word_cnt_q, word_cnt_d;
  logic [7:0]        sum_q, sum_d;
  logic [23:0]       shift_q, shift_d;

  logic [WCW-1:0]    n_words;
  logic [7:0]        sum_final;
  logic              expired;

  assign n_words   = (rx_data == 8'd0) ? WCNT_MAX : WCW'(rx_data);
  assign sum_final = sum_q + rx_data;

  loader_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (rx_valid || (state_q == IDLE)),
    .en      (state_q != IDLE),
    .expired (expired)
  );

  // Frame parser: next state, word assembly, write strobe and status flags.
  always_comb begin
    state_d     = state_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    load_done_d = load_done_q;
    load_err_d  = load_err_q;
    byte_idx_d  = byte_idx_q;
    word_cnt_d  = word_cnt_q;
    sum_d       = sum_q;
    shift_d     = shift_q;

    // Address advances on the edge that ends each write pulse.
    if (mem_we_q) begin
      mem_addr_d = mem_addr_q + ADDR_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (rx_valid && (rx_data == MAGIC)) begin
          state_d     = COUNT;
          cpu_hold_d  = 1'b1;
          load_done_d = 1'b0;
          load_err_d  = 1'b0;
          sum_d       = '0;
          mem_addr_d  = '0;
        end
      end
      COUNT: begin
        if (rx_valid) begin
          word_cnt_d = n_words;
          sum_d      = rx_data;
          byte_idx_d = '0;
          state_d    = DATA;
        end else if (expired) begin
          load_err_d = 1'b1;
          state_d    = IDLE;
        end
      end
      DATA: begin
        if (rx_valid) begin
          sum_d      = sum_q + rx_data;
          shift_d    = {shift_q[15:0], rx_data};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            mem_wdata_d = {shift_q, rx_data};
            mem_we_d    = 1'b1;
            word_cnt_d  = word_cnt_q - WCNT_ONE;
            if (word_cnt_q == WCNT_ONE) begin
              state_d = CSUM;
            end
          end
        end else if (expired) begin
          load_err_d = 1'b1;
          state_d    = IDLE;
        end
      end
      CSUM: begin
        if (rx_valid) begin
          if (sum_final == 8'd0) begin
            load_done_d = 1'b1;
            cpu_hold_d  = 1'b0;
          end else begin
            load_err_d = 1'b1;
          end
          state_d = IDLE;
        end else if (expired) begin
          load_err_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset also cancels an in-flight write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      byte_idx_q  <= '0;
      word_cnt_q  <= '0;
      sum_q       <= '0;
      shift_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
      byte_idx_q  <= byte_idx_d;
      word_cnt_q  <= word_cnt_d;
      sum_q       <= sum_d;
      shift_q     <= shift_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_busy = (state_q != IDLE);
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader with a write scoreboard.
module tb_imem_uart_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_busy;
  logic        load_done;
  logic        load_err;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] words [256];
  logic [7:0]  exp_addr;

  imem_uart_loader #(
    .ADDR_W  (8),
    .TIMEOUT (16),
    .MAGIC   (8'hA5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .load_busy (load_busy),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_pending", 64'(exp_q.size()), 64'd1);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", 64'(mem_addr), 64'(e.a));
        chk("write_data", 64'(mem_wdata), 64'(e.d));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Sends a frame of words[0..nwords-1]; cbias is added to the correct checksum.
  task automatic send_frame(input int nwords, input logic [7:0] cbias);
    logic [7:0]  sum;
    logic [7:0]  b;
    logic [31:0] wd;
    logic [31:0] nw;
    send_byte(8'hA5);
    chk("hold_in_frame", 64'(cpu_hold), 64'd1);
    chk("busy_in_frame", 64'(load_busy), 64'd1);
    nw  = nwords;
    b   = nw[7:0];
    sum = b;
    send_byte(b);
    exp_addr = 8'd0;
    for (int w = 0; w < nwords; w++) begin
      wd = words[w];
      for (int k = 0; k < 4; k++) begin
        b   = wd[31-8*k -: 8];
        sum = sum + b;
        if (k == 3) begin
          exp_q.push_back('{a: exp_addr, d: wd});
          exp_addr = exp_addr + 8'd1;
        end
        send_byte(b);
        chk("we_latency", 64'(mem_we), 64'(k == 3));
      end
    end
    send_byte(8'(8'd0 - sum) + cbias);
    chk("all_writes_seen", 64'(exp_q.size()), 64'd0);
    chk("addr_after_frame", 64'(mem_addr), 64'(exp_addr));
    chk("busy_after_frame", 64'(load_busy), 64'd0);
  endtask

  task automatic chk_status(input string tag, input logic done, input logic err, input logic hold);
    chk({tag, "_done"}, 64'(load_done), 64'(done));
    chk({tag, "_err"},  64'(load_err),  64'(err));
    chk({tag, "_hold"}, 64'(cpu_hold),  64'(hold));
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_we"},    64'(mem_we),    64'd0);
    chk({tag, "_addr"},  64'(mem_addr),  64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_busy"},  64'(load_busy), 64'd0);
    chk_status(tag, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);

    // Single word, good checksum F4.
    words[0] = 32'h0800_0003;
    send_frame(1, 8'd0);
    chk_status("single", 1'b1, 1'b0, 1'b0);

    // Three words, good checksum.
    words[0] = 32'h0800_0003;
    words[1] = 32'h0800_002E;
    words[2] = 32'h0800_0077;
    send_frame(3, 8'd0);
    chk_status("three", 1'b1, 1'b0, 1'b0);

    // Bad checksum (F5) still writes, then flags error and keeps CPU held.
    words[0] = 32'h0800_0003;
    send_frame(1, 8'd1);
    chk_status("badcsum", 1'b0, 1'b1, 1'b1);
    send_frame(1, 8'd0);
    chk_status("recover", 1'b1, 1'b0, 1'b0);

    // Timeout: frame stalls mid-word.
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h20);
    send_byte(8'h08);
    n = 0;
    while (load_err !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_not_early", 64'(n >= 14), 64'd1);
    chk("timeout_not_late", 64'(n <= 20), 64'd1);
    chk_status("timeout", 1'b0, 1'b1, 1'b1);
    chk("timeout_idle", 64'(load_busy), 64'd0);
    send_byte(8'h08);
    chk("stray_ignored", 64'(load_busy), 64'd0);
    chk("stray_err_kept", 64'(load_err), 64'd1);

    // N=0: 256 words of byte pattern i[7:0]; addresses wrap back to 0.
    for (int w = 0; w < 256; w++) begin
      words[w] = {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)};
    end
    send_frame(256, 8'd0);
    chk("wrap_addr_zero", 64'(mem_addr), 64'd0);
    chk_status("full", 1'b1, 1'b0, 1'b0);

    // Reset one cycle after the 2nd data byte of a word.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h08);
    send_byte(8'h00);
    chk("pre_reset_hold", 64'(cpu_hold), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_values("midreset");
    send_byte(8'h00);
    send_byte(8'h03);
    repeat (3) @(negedge clk);
    chk("midreset_no_write_busy", 64'(load_busy), 64'd0);
    chk("midreset_no_pending", 64'(exp_q.size()), 64'd0);
    chk_reset_values("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
